// File: rtl/regfile_write_arbiter.sv
// Shares the register-bank write port between WB (always wins) and a queued aux unit (MULT/DIV).
// Optional same-cycle aux bypass into an idle, empty port is enabled by defining WARB_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_write_reg,
    input  logic [31:0] aux_write_data,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    output logic        hazard1,
    output logic        hazard2,
    output logic        stall_req,
    output logic        rf_reg_write,
    output logic [4:0]  rf_write_reg,
    output logic [31:0] rf_write_data
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  reg_idx;
        logic [31:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [STV_W-1:0] starve_cnt;
    logic             empty;
    logic             push;
    logic             pop;
    logic             bypass;
    entry_t           head;

    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_comb begin
        aux_ready = !reset && (count != CNT_W'(DEPTH));
    end

`ifdef WARB_BYPASS_EN
    assign bypass = empty && !wb_reg_write && aux_valid && aux_ready && (aux_write_reg != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    // Register-0 results complete the handshake but are never stored
    assign push = aux_valid && aux_ready && (aux_write_reg != 5'd0) && !bypass;
    assign pop  = !reset && !wb_reg_write && !empty;

    // Write-port select: WB, then FIFO head, then (optionally) the incoming aux result
    always_comb begin
        rf_reg_write  = 1'b0;
        rf_write_reg  = 5'd0;
        rf_write_data = 32'd0;
        if (!reset) begin
            if (wb_reg_write) begin
                rf_reg_write  = 1'b1;
                rf_write_reg  = wb_write_reg;
                rf_write_data = wb_write_data;
            end else if (!empty) begin
                rf_reg_write  = 1'b1;
                rf_write_reg  = head.reg_idx;
                rf_write_data = head.data;
            end else if (bypass) begin
                rf_reg_write  = 1'b1;
                rf_write_reg  = aux_write_reg;
                rf_write_data = aux_write_data;
            end
        end
    end

    // RAW hazard against entries currently held in the FIFO
    always_comb begin
        hazard1 = 1'b0;
        hazard2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                if (mem[rd_ptr + PTR_W'(i)].reg_idx == read_reg1) hazard1 = 1'b1;
                if (mem[rd_ptr + PTR_W'(i)].reg_idx == read_reg2) hazard2 = 1'b1;
            end
        end
        if (reset || (read_reg1 == 5'd0)) hazard1 = 1'b0;
        if (reset || (read_reg2 == 5'd0)) hazard2 = 1'b0;
    end

    always_comb begin
        stall_req = !reset && (starve_cnt == STV_W'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {aux_write_reg, aux_write_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
            // Counts cycles a queued result is blocked by WB; saturates
            if (pop || empty)
                starve_cnt <= '0;
            else if (wb_reg_write && (starve_cnt != STV_W'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + STV_W'(1);
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: a negedge monitor checks every write and hazard
// against a queue of accepted aux results; scenario tasks check specific behaviours inline.
module tb_regfile_write_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_write_reg;
    logic [31:0] aux_write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic        hazard1;
    logic        hazard2;
    logic        stall_req;
    logic        rf_reg_write;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_write_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;
    exp_t q[$];

    regfile_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
        .aux_valid(aux_valid), .aux_ready(aux_ready),
        .aux_write_reg(aux_write_reg), .aux_write_data(aux_write_data),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .hazard1(hazard1), .hazard2(hazard2), .stall_req(stall_req),
        .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Scoreboard monitor: state of q at the negedge equals the FIFO contents
    always @(negedge clk) begin : monitor
        logic exp_acc, byp, h1, h2;
        exp_t e;
        if (reset) begin
            checks++;
            if (rf_reg_write !== 1'b0 || rf_write_reg !== 5'd0 || rf_write_data !== 32'd0 ||
                aux_ready !== 1'b0 || hazard1 !== 1'b0 || hazard2 !== 1'b0 || stall_req !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs rf=%b/%0d/%h rdy=%b hz=%b%b stall=%b exp all zero",
                         rf_reg_write, rf_write_reg, rf_write_data, aux_ready, hazard1, hazard2, stall_req);
            end
            q.delete();
        end else begin
            checks++;
            if (aux_ready !== (q.size() != DEPTH)) begin
                errors++;
                $display("FAIL aux_ready act=%b exp=%b", aux_ready, q.size() != DEPTH);
            end
            h1 = 1'b0;
            h2 = 1'b0;
            foreach (q[i]) begin
                if (q[i].r == read_reg1) h1 = 1'b1;
                if (q[i].r == read_reg2) h2 = 1'b1;
            end
            h1 = h1 && (read_reg1 != 5'd0);
            h2 = h2 && (read_reg2 != 5'd0);
            checks++;
            if (hazard1 !== h1 || hazard2 !== h2) begin
                errors++;
                $display("FAIL hazard act=%b%b exp=%b%b", hazard1, hazard2, h1, h2);
            end
            exp_acc = aux_valid && (q.size() != DEPTH);
            byp = 1'b0;
`ifdef WARB_BYPASS_EN
            byp = exp_acc && (q.size() == 0) && !wb_reg_write && (aux_write_reg != 5'd0);
`endif
            checks++;
            if (wb_reg_write) begin
                if (rf_reg_write !== 1'b1 || rf_write_reg !== wb_write_reg || rf_write_data !== wb_write_data) begin
                    errors++;
                    $display("FAIL wb_pass act=%b/%0d/%h exp=1/%0d/%h",
                             rf_reg_write, rf_write_reg, rf_write_data, wb_write_reg, wb_write_data);
                end
            end else if (q.size() != 0) begin
                e = q.pop_front();
                if (rf_reg_write !== 1'b1 || rf_write_reg !== e.r || rf_write_data !== e.d) begin
                    errors++;
                    $display("FAIL fifo_write act=%b/%0d/%h exp=1/%0d/%h",
                             rf_reg_write, rf_write_reg, rf_write_data, e.r, e.d);
                end
            end else if (byp) begin
                if (rf_reg_write !== 1'b1 || rf_write_reg !== aux_write_reg || rf_write_data !== aux_write_data) begin
                    errors++;
                    $display("FAIL bypass_write act=%b/%0d/%h exp=1/%0d/%h",
                             rf_reg_write, rf_write_reg, rf_write_data, aux_write_reg, aux_write_data);
                end
            end else begin
                if (rf_reg_write !== 1'b0 || rf_write_reg !== 5'd0 || rf_write_data !== 32'd0) begin
                    errors++;
                    $display("FAIL idle_write act=%b/%0d/%h exp=0/0/0",
                             rf_reg_write, rf_write_reg, rf_write_data);
                end
            end
            if (exp_acc && (aux_write_reg != 5'd0) && !byp) begin
                e.r = aux_write_reg;
                e.d = aux_write_data;
                q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_reg_write   = 1'b0;
        wb_write_reg   = 5'd0;
        wb_write_data  = 32'd0;
        aux_valid      = 1'b0;
        aux_write_reg  = 5'd0;
        aux_write_data = 32'd0;
        read_reg1      = 5'd0;
        read_reg2      = 5'd0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        wb_reg_write = 1'b1; wb_write_reg = 5'd4; wb_write_data = 32'h1234;
        aux_valid = 1'b1; aux_write_reg = 5'd2; read_reg1 = 5'd2;
        @(negedge clk);
        checks++;
        if (rf_reg_write !== 1'b0 || aux_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold rf_we=%b rdy=%b exp 0 0", rf_reg_write, aux_ready);
        end
        tick();
        reset = 1'b0;
        idle();
        wb_reg_write = 1'b1; wb_write_reg = 5'd1; aux_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            aux_write_reg  = 5'(21 + i);
            aux_write_data = 32'(100 + i);
            tick();
        end
        aux_valid = 1'b0; read_reg1 = 5'd21;
        @(negedge clk);
        checks++;
        if (hazard1 !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefill_hazard act=%b exp=1", hazard1);
        end
        tick();
        wb_reg_write = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (rf_reg_write !== 1'b0 || hazard1 !== 1'b0 || aux_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_async rf_we=%b hz1=%b rdy=%b exp 0 0 0", rf_reg_write, hazard1, aux_ready);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (aux_ready !== 1'b1 || rf_reg_write !== 1'b0 || hazard1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rdy=%b rf_we=%b hz1=%b exp 1 0 0", aux_ready, rf_reg_write, hazard1);
        end
        tick();
    endtask

    task automatic test_wb_priority();
        idle();
        wb_reg_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'h11;
        aux_valid = 1'b1; aux_write_reg = 5'd6; aux_write_data = 32'hAA;
        @(negedge clk);
        checks++;
        if (rf_write_reg !== 5'd5 || rf_write_data !== 32'h11) begin
            errors++;
            $display("FAIL wb_first act=%0d/%h exp=5/11", rf_write_reg, rf_write_data);
        end
        tick();
        idle();
        @(negedge clk);
        checks++;
        if (rf_reg_write !== 1'b1 || rf_write_reg !== 5'd6 || rf_write_data !== 32'hAA) begin
            errors++;
            $display("FAIL aux_next act=%b/%0d/%h exp=1/6/aa", rf_reg_write, rf_write_reg, rf_write_data);
        end
        tick();
    endtask

    task automatic test_full();
        idle();
        wb_reg_write = 1'b1; wb_write_reg = 5'd1; wb_write_data = 32'hF0F0; aux_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            aux_write_reg  = 5'(10 + i);
            aux_write_data = 32'(256 + i);
            @(negedge clk);
            checks++;
            if (aux_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_fill_ready idx=%0d act=%b exp=1", i, aux_ready);
            end
            tick();
        end
        aux_write_reg = 5'd14; aux_write_data = 32'h104;
        @(negedge clk);
        checks++;
        if (aux_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready act=%b exp=0", aux_ready);
        end
        tick();
        wb_reg_write = 1'b0;
        @(negedge clk);
        checks++;
        if (aux_ready !== 1'b0 || rf_write_reg !== 5'd10) begin
            errors++;
            $display("FAIL full_pop rdy=%b reg=%0d exp 0 10", aux_ready, rf_write_reg);
        end
        tick();
        @(negedge clk);
        checks++;
        if (aux_ready !== 1'b1 || rf_write_reg !== 5'd11) begin
            errors++;
            $display("FAIL full_accept rdy=%b reg=%0d exp 1 11", aux_ready, rf_write_reg);
        end
        tick();
        aux_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (rf_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL full_drained act=%b exp=0", rf_reg_write);
        end
        tick();
    endtask

    task automatic test_starvation();
        idle();
        wb_reg_write = 1'b1; wb_write_reg = 5'd2; wb_write_data = 32'h22;
        aux_valid = 1'b1; aux_write_reg = 5'd7; aux_write_data = 32'h77;
        tick();
        aux_valid = 1'b0;
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            @(negedge clk);
            checks++;
            if (stall_req !== 1'b0) begin
                errors++;
                $display("FAIL starve_early cycle=%0d act=%b exp=0", i, stall_req);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (stall_req !== 1'b1) begin
            errors++;
            $display("FAIL starve_assert act=%b exp=1", stall_req);
        end
        tick();
        wb_reg_write = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_req !== 1'b1 || rf_write_reg !== 5'd7) begin
            errors++;
            $display("FAIL starve_bubble stall=%b reg=%0d exp 1 7", stall_req, rf_write_reg);
        end
        tick();
        @(negedge clk);
        checks++;
        if (stall_req !== 1'b0) begin
            errors++;
            $display("FAIL starve_drop act=%b exp=0", stall_req);
        end
        tick();
    endtask

    task automatic test_hazard();
        idle();
        wb_reg_write = 1'b1; wb_write_reg = 5'd3; wb_write_data = 32'h33;
        aux_valid = 1'b1; aux_write_reg = 5'd9; aux_write_data = 32'h99;
        read_reg1 = 5'd9; read_reg2 = 5'd0;
        @(negedge clk);
        checks++;
        if (hazard1 !== 1'b0) begin
            errors++;
            $display("FAIL hazard_push_invisible act=%b exp=0", hazard1);
        end
        tick();
        aux_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (hazard1 !== 1'b1 || hazard2 !== 1'b0) begin
            errors++;
            $display("FAIL hazard_queued act=%b%b exp=10", hazard1, hazard2);
        end
        read_reg2 = 5'd9;
        #1;
        checks++;
        if (hazard2 !== 1'b1) begin
            errors++;
            $display("FAIL hazard2_queued act=%b exp=1", hazard2);
        end
        tick();
        wb_reg_write = 1'b0;
        tick();
        @(negedge clk);
        checks++;
        if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
            errors++;
            $display("FAIL hazard_drained act=%b%b exp=00", hazard1, hazard2);
        end
        tick();
        aux_valid = 1'b1; aux_write_reg = 5'd0; aux_write_data = 32'hDEAD; read_reg1 = 5'd0;
        tick();
        aux_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rf_reg_write !== 1'b0 || aux_ready !== 1'b1) begin
            errors++;
            $display("FAIL r0_drop rf_we=%b rdy=%b exp 0 1", rf_reg_write, aux_ready);
        end
        tick();
    endtask

    task automatic test_bypass();
        idle();
        aux_valid = 1'b1; aux_write_reg = 5'd3; aux_write_data = 32'h55;
        @(negedge clk);
        checks++;
`ifdef WARB_BYPASS_EN
        if (rf_reg_write !== 1'b1 || rf_write_reg !== 5'd3 || rf_write_data !== 32'h55) begin
            errors++;
            $display("FAIL bypass_same act=%b/%0d/%h exp=1/3/55", rf_reg_write, rf_write_reg, rf_write_data);
        end
`else
        if (rf_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL nobypass_same act=%b exp=0", rf_reg_write);
        end
`endif
        tick();
        aux_valid = 1'b0;
        @(negedge clk);
        checks++;
`ifdef WARB_BYPASS_EN
        if (rf_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL bypass_next act=%b exp=0", rf_reg_write);
        end
`else
        if (rf_reg_write !== 1'b1 || rf_write_reg !== 5'd3 || rf_write_data !== 32'h55) begin
            errors++;
            $display("FAIL nobypass_next act=%b/%0d/%h exp=1/3/55", rf_reg_write, rf_write_reg, rf_write_data);
        end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 80; i++) begin
            wb_reg_write   = ($urandom_range(0, 2) == 0);
            wb_write_reg   = 5'($urandom_range(0, 31));
            wb_write_data  = $urandom;
            aux_valid      = ($urandom_range(0, 1) == 1);
            aux_write_reg  = 5'($urandom_range(0, 31));
            aux_write_data = $urandom;
            read_reg1      = 5'($urandom_range(0, 31));
            read_reg2      = 5'($urandom_range(0, 31));
            tick();
        end
        idle();
        repeat (DEPTH + 1) tick();
        @(negedge clk);
        checks++;
        if (rf_reg_write !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drained rf_we=%b pending=%0d exp 0 0", rf_reg_write, q.size());
        end
        tick();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        test_reset();
        test_wb_priority();
        test_full();
        test_starvation();
        test_hazard();
        test_bypass();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
